// File: rtl/conv_8b_32b.sv
// conv_8b_32b: 8-bit to 32-bit deserializer on the byte-rate clock.
// Collects four consecutive valid bytes MSB-first (first byte -> [31:24]) and
// presents the word for four clk_4f cycles (one clk_f period).
//
// Ports:
//   clk_4f    in   1   byte-rate clock, rising edge
//   reset     in   1   synchronous active-high reset
//   data_in   in   8   incoming byte
//   valid_in  in   1   data_in holds a valid byte this cycle
//   data_out  out  32  assembled word, INVALID_DATA while valid_out=0
//   valid_out out  1   data_out holds a complete word
//   frame_err out  1   one-cycle pulse when a partial word is aborted
//   byte_cnt  out  2   next byte slot to fill (bytes currently held)
module conv_8b_32b #(
    parameter logic [31:0] INVALID_DATA = 32'h0000_0000
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        frame_err,
    output logic [1:0]  byte_cnt
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [1:0]  hold_q, hold_d;
    logic        ferr_q, ferr_d;
    logic        complete;

    // 4th byte of a word sampled this edge
    assign complete = (state_q == StCollect) && valid_in && (cnt_q == 2'd3);

    // State register
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (valid_in) state_d = StCollect;
            StCollect: if (!valid_in || cnt_q == 2'd3) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath and output-window next state
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ferr_d  = 1'b0;
        word_d  = word_q;
        valid_d = valid_q;
        hold_d  = hold_q;

        if (valid_in) begin
            if (complete) begin
                shift_d = '0;
                cnt_d   = 2'd0;
            end else begin
                case (cnt_q)
                    2'd0: shift_d[31:24] = data_in;
                    2'd1: shift_d[23:16] = data_in;
                    2'd2: shift_d[15:8]  = data_in;
                    2'd3: shift_d[7:0]   = data_in;
                endcase
                cnt_d = cnt_q + 2'd1;
            end
        end else if (state_q == StCollect) begin
            // Abort: drop the partial word; the output window is left alone
            ferr_d  = 1'b1;
            shift_d = '0;
            cnt_d   = 2'd0;
        end

        // A completion always reloads the window, even mid-window
        if (complete) begin
            word_d  = {shift_q[31:8], data_in};
            valid_d = 1'b1;
            hold_d  = 2'd3;
        end else if (valid_q) begin
            if (hold_q == 2'd0) begin
                valid_d = 1'b0;
                word_d  = INVALID_DATA;
            end else begin
                hold_d = hold_q - 2'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= INVALID_DATA;
            valid_q <= 1'b0;
            hold_q  <= 2'd0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            ferr_q  <= ferr_d;
        end
    end

    // Outputs
    always_comb begin
        data_out  = valid_q ? word_q : INVALID_DATA;
        valid_out = valid_q;
        frame_err = ferr_q;
        byte_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_conv_8b_32b.sv
// Testbench for conv_8b_32b: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_conv_8b_32b;

    logic        clk_4f;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        frame_err;
    logic [1:0]  byte_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the partial word, current word, cycles left in window
    logic [7:0]  m_q[$];
    logic [31:0] m_word = 32'h0;
    int          m_left = 0;
    logic        m_ferr = 1'b0;

    conv_8b_32b dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .frame_err(frame_err),
        .byte_cnt (byte_cnt)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [7:0] d);
        logic [31:0] w;
        logic        done;
        done = 1'b0;
        w    = 32'h0;
        if (r) begin
            m_q.delete();
            m_word = 32'h0;
            m_left = 0;
            m_ferr = 1'b0;
        end else begin
            m_ferr = (m_q.size() > 0) && !v;
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    w    = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    done = 1'b1;
                    m_q.delete();
                end
            end else begin
                m_q.delete();
            end
            if (done) begin
                m_word = w;
                m_left = 4;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    endtask

    task automatic compare();
        chk("data_out", data_out, (m_left > 0) ? m_word : 32'h0);
        chk("valid_out", {31'h0, valid_out}, {31'h0, m_left > 0});
        chk("frame_err", {31'h0, frame_err}, {31'h0, m_ferr});
        chk("byte_cnt", {30'h0, byte_cnt}, m_q.size());
    endtask

    // One clock: apply inputs, step model, sample outputs 1 time unit after the edge
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        model_update(r, v, d);
        #1;
        compare();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i*8 +: 8]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // 1: reset held with valid traffic on the inputs
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        idle(1);
        chk("reset_data", data_out, 32'h0);

        // 2: single word then idle
        send_word(32'hAABBCCDD);
        chk("single_word", data_out, 32'hAABBCCDD);
        idle(3);
        chk("single_hold_last", data_out, 32'hAABBCCDD);
        idle(1);
        chk("single_expired", {31'h0, valid_out}, 32'h0);
        idle(1);

        // 3: back-to-back words
        send_word(32'h11223344);
        chk("b2b_first", data_out, 32'h11223344);
        send_word(32'h55667788);
        chk("b2b_second", data_out, 32'h55667788);
        idle(5);

        // 4: abort then good word
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_ferr", {31'h0, frame_err}, 32'h1);
        send_word(32'hA0A1A2A3);
        chk("abort_recover", data_out, 32'hA0A1A2A3);
        idle(5);

        // 5: abort during an active window
        send_word(32'hDEADBEEF);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        step(1'b0, 1'b0, 8'h00);
        chk("win_abort_ferr", {31'h0, frame_err}, 32'h1);
        chk("win_abort_data", data_out, 32'hDEADBEEF);
        idle(2);

        // 6: reset in the middle of a word
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b1, 1'b0, 8'h00);
        chk("mid_reset_cnt", {30'h0, byte_cnt}, 32'h0);
        send_word(32'h01020304);
        chk("mid_reset_word", data_out, 32'h01020304);
        idle(5);

        // Random traffic, mostly valid, occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
